// File: rtl/io_page_pkg.sv
// IO-page address decode bits, UART status bit positions and serializer state encoding.
package io_page_pkg;

  localparam int unsigned IO_LEDS_bit      = 0;
  localparam int unsigned IO_UART_DAT_bit  = 1;
  localparam int unsigned IO_UART_CNTL_bit = 2;

  localparam int unsigned UART_OVF_bit    = 10;
  localparam int unsigned UART_FULL_bit   = 9;
  localparam int unsigned UART_ACTIVE_bit = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: DAT write pushes a byte into a FIFO, CNTL reads status.
module io_uart_tx
  import io_page_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 1000000,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [29:0] io_wordaddr,
  input  logic        io_sel,
  input  logic [31:0] io_wdata,
  input  logic        io_wstrb,
  output logic [31:0] io_rdata,
  output logic        TXD
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned BW  = $clog2(DIV);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;

  logic          dat_wr, cntl_wr, fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty, baud_end, active;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [8:0]    count_ext;
  logic          unused_bits;

  assign dat_wr      = io_sel && io_wstrb && io_wordaddr[IO_UART_DAT_bit];
  assign cntl_wr     = io_sel && io_wstrb && io_wordaddr[IO_UART_CNTL_bit];
  assign fifo_push   = dat_wr && !fifo_full;
  assign baud_end    = (baud_q == BW'(DIV - 1));
  assign active      = (state_q != TX_IDLE) || !fifo_empty;
  assign count_ext   = 9'(fifo_count);
  assign TXD         = txd_q;
  assign unused_bits = ^{io_wordaddr[29:3], io_wordaddr[0], io_wdata[31:8], count_ext[8]};

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (io_wdata[7:0]),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    io_rdata = '0;
    if (io_sel && io_wordaddr[IO_UART_CNTL_bit]) begin
      io_rdata[UART_OVF_bit]    = ovf_q;
      io_rdata[UART_FULL_bit]   = fifo_full;
      io_rdata[UART_ACTIVE_bit] = active;
      io_rdata[7:0]             = count_ext[7:0];
    end
  end

  // Overflow is applied after the clear so a simultaneous overflow wins.
  always_comb begin
    ovf_d = ovf_q;
    if (cntl_wr)              ovf_d = 1'b0;
    if (dat_wr && fifo_full)  ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = TX_START;
          txd_d    = 1'b0;
          shreg_d  = fifo_dout;
          baud_d   = '0;
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
          txd_d   = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = TX_START;
            txd_d    = 1'b0;
            shreg_d  = fifo_dout;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
